// File: rtl/strum_judge_ctrl.sv
// Rhythm-game note judge: steps a chart ROM once per beat, opens a hit window per note and judges strums.
// Optional STRUM_SYNC_EN adds 2-flop synchronizers on strum and buttons (pulse latency 3 cycles from pin).
module strum_judge_ctrl #(
  parameter int BEAT_CYCLES   = 2500000,
  parameter int WINDOW_CYCLES = 1250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic [4:0] buttons,
  input  logic       strum,
  output logic [7:0] rom_addr,
  input  logic [5:0] rom_data,
  output logic [4:0] notes_to_play,
  output logic       note_hit,
  output logic       note_miss,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int WW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW_CYCLES - 1);

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_beat_cnt;
  logic [WW-1:0] r_win_cnt;
  logic          r_win_open;
  logic [7:0]    r_rom_addr;
  logic [4:0]    r_notes;
  logic          r_hit, r_miss;
  logic          r_strum_prev;

  logic          w_strum;
  logic [4:0]    w_buttons;

`ifdef STRUM_SYNC_EN
  logic       r_strum_s1, r_strum_s2;
  logic [4:0] r_btn_s1, r_btn_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_strum_s1 <= 1'b0;
      r_strum_s2 <= 1'b0;
      r_btn_s1   <= '0;
      r_btn_s2   <= '0;
    end else begin
      r_strum_s1 <= strum;
      r_strum_s2 <= r_strum_s1;
      r_btn_s1   <= buttons;
      r_btn_s2   <= r_btn_s1;
    end
  end

  assign w_strum   = r_strum_s2;
  assign w_buttons = r_btn_s2;
`else
  assign w_strum   = strum;
  assign w_buttons = buttons;
`endif

  logic w_advance, w_terminal, w_go_done, w_judge;
  logic w_strum_edge, w_expire, w_match, w_hit_d, w_miss_d;

  // Play logic only moves in PLAY with neither stop nor pause asserted; this is what freezes everything in PAUSE.
  assign w_advance    = (r_state == ST_PLAY) && !stop && !pause;
  assign w_terminal   = (r_beat_cnt == BEAT_LAST);
  assign w_go_done    = w_advance && w_terminal && rom_data[5];
  assign w_judge      = w_advance && !w_go_done;
  assign w_strum_edge = w_strum && !r_strum_prev;
  assign w_expire     = r_win_open && (r_win_cnt == WIN_LAST);
  assign w_match      = (w_buttons == r_notes);
  assign w_hit_d      = w_judge && w_strum_edge && r_win_open && w_match;
  assign w_miss_d     = w_judge && ((w_strum_edge && !(r_win_open && w_match)) ||
                                    (!w_strum_edge && w_expire));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
    w_state_nxt = r_state;
    if (stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (!pause && start) w_state_nxt = ST_PLAY;
        ST_PLAY:  if (pause) w_state_nxt = ST_PAUSE;
                  else if (w_terminal && rom_data[5]) w_state_nxt = ST_DONE;
        ST_PAUSE: if (!pause) w_state_nxt = ST_PLAY;
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat_cnt   <= '0;
      r_win_cnt    <= '0;
      r_win_open   <= 1'b0;
      r_rom_addr   <= '0;
      r_notes      <= '0;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_strum_prev <= 1'b0;
    end else begin
      r_strum_prev <= w_strum;
      r_hit        <= w_hit_d;
      r_miss       <= w_miss_d;
      if (stop) begin
        r_beat_cnt <= '0;
        r_win_cnt  <= '0;
        r_win_open <= 1'b0;
        r_rom_addr <= '0;
        r_notes    <= '0;
      end else if (w_advance) begin
        r_beat_cnt <= w_terminal ? '0 : r_beat_cnt + BW'(1);
        if (w_terminal) begin
          r_win_cnt <= '0;
          if (rom_data[5]) begin
            r_win_open <= 1'b0;
            r_notes    <= '0;
          end else begin
            r_notes    <= rom_data[4:0];
            r_win_open <= |rom_data[4:0];
            r_rom_addr <= r_rom_addr + 8'd1;
          end
        end else if (r_win_open) begin
          if (w_strum_edge || w_expire) begin
            r_win_open <= 1'b0;
            r_win_cnt  <= '0;
            r_notes    <= '0;
          end else begin
            r_win_cnt <= r_win_cnt + WW'(1);
          end
        end
      end
    end
  end

  assign rom_addr      = r_rom_addr;
  assign notes_to_play = r_notes;
  assign note_hit      = r_hit;
  assign note_miss     = r_miss;
  assign state         = r_state;

endmodule

// File: tb/tb_strum_judge_ctrl.sv
// Scoreboard bench for strum_judge_ctrl (BEAT_CYCLES=8, WINDOW_CYCLES=4, default build).
module tb_strum_judge_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, pause, stop, strum;
  logic [4:0] buttons;
  logic [7:0] rom_addr;
  logic [5:0] rom_data;
  logic [4:0] notes_to_play;
  logic       note_hit, note_miss;
  logic [1:0] state;

  logic [5:0] rom [256];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  typedef struct {
    logic is_hit;
    int   cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  strum_judge_ctrl #(.BEAT_CYCLES(8), .WINDOW_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
    .buttons(buttons), .strum(strum), .rom_addr(rom_addr), .rom_data(rom_data),
    .notes_to_play(notes_to_play), .note_hit(note_hit), .note_miss(note_miss),
    .state(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Pulse monitor: every judgment pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!reset && (note_hit || note_miss)) begin
      if (note_hit && note_miss) check("hit_and_miss_together", 1, 0);
      check("pulse_state_play", state, 1);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind_hit", note_hit, mon_e.is_hit);
        check("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic is_hit, input int c);
    exp_t e;
    e.is_hit = is_hit;
    e.cyc    = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic do_reset();
    check("pending_pulses", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; strum = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    s = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_rom(input logic [5:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  initial begin
    int s, ld;
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; strum = 1'b0; buttons = '0;
    fill_rom(6'h20);
    repeat (3) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_notes", notes_to_play, 0);
    check("rst_hit", note_hit, 0);
    check("rst_miss", note_miss, 0);
    reset = 1'b0;

    // Matching chord struck two cycles after load, then the end marker.
    fill_rom(6'h20); rom[0] = 6'h05; rom[1] = 6'h20;
    buttons = 5'b00101;
    do_start(s);
    ld = s + 9;
    wait_until(s + 1); check("s1_play", state, 1);
    wait_until(ld - 1); check("s1_pre_load_notes", notes_to_play, 0);
    wait_until(ld);
    check("s1_load_notes", notes_to_play, 5);
    check("s1_addr_inc", rom_addr, 1);
    wait_until(ld + 1); strum = 1'b1; push_exp(1'b1, ld + 2);
    wait_until(ld + 2); check("s1_notes_cleared", notes_to_play, 0);
    wait_until(ld + 3); strum = 1'b0;
    wait_until(ld + 7); check("s1_still_play", state, 1);
    wait_until(ld + 8); check("s1_done", state, 3); check("s1_done_notes", notes_to_play, 0);
    wait_until(ld + 12); check("s1_done_held", state, 3);
    stop = 1'b1;
    wait_until(ld + 13); stop = 1'b0; check("s1_stop_idle", state, 0);
    do_reset();

    // Wrong chord on strum gives a miss.
    fill_rom(6'h20); rom[0] = 6'h03;
    buttons = 5'b00001;
    do_start(s); ld = s + 9;
    wait_until(ld); check("s2a_notes", notes_to_play, 3);
    strum = 1'b1; push_exp(1'b0, ld + 1);
    wait_until(ld + 1); check("s2a_notes_cleared", notes_to_play, 0);
    strum = 1'b0;
    wait_until(ld + 6);
    do_reset();

    // No strum: the window expires into a miss exactly 4 cycles after load.
    do_start(s); ld = s + 9;
    push_exp(1'b0, ld + 4);
    wait_until(ld + 3); check("s2b_notes_open", notes_to_play, 3);
    wait_until(ld + 4); check("s2b_notes_expired", notes_to_play, 0);
    wait_until(ld + 7);
    do_reset();

    // Strum edge in the expiry cycle with matching buttons: exactly one hit.
    buttons = 5'b00011;
    do_start(s); ld = s + 9;
    wait_until(ld + 3); strum = 1'b1; push_exp(1'b1, ld + 4);
    wait_until(ld + 4); check("s3_notes_cleared", notes_to_play, 0);
    wait_until(ld + 6); strum = 1'b0;
    do_reset();

    // Reset mid-window clears everything and no pulse follows.
    do_start(s); ld = s + 9;
    wait_until(ld + 1); reset = 1'b1;
    wait_until(ld + 2);
    check("s4_rst_state", state, 0);
    check("s4_rst_notes", notes_to_play, 0);
    check("s4_rst_addr", rom_addr, 0);
    reset = 1'b0;
    wait_until(ld + 8);
    do_reset();

    // Pause 20 cycles mid-window with strum raised and held: no edge, window resumes.
    fill_rom(6'h20); rom[0] = 6'h06;
    buttons = 5'b00110;
    do_start(s); ld = s + 9;
    wait_until(ld + 1); pause = 1'b1;
    wait_until(ld + 2); check("s5_pause_state", state, 2);
    wait_until(ld + 3); strum = 1'b1;
    wait_until(ld + 21);
    check("s5_frozen_notes", notes_to_play, 6);
    check("s5_frozen_addr", rom_addr, 1);
    check("s5_frozen_state", state, 2);
    pause = 1'b0;
    push_exp(1'b0, ld + 25);
    wait_until(ld + 22); check("s5_resume", state, 1);
    wait_until(ld + 24); check("s5_window_left", notes_to_play, 6);
    wait_until(ld + 25); check("s5_window_closed", notes_to_play, 0);
    wait_until(ld + 28); check("s5_beat_frozen_play", state, 1);
    wait_until(ld + 29); check("s5_beat_frozen_done", state, 3);
    stop = 1'b1; pause = 1'b1;
    wait_until(ld + 30); check("s5_stop_over_pause", state, 0);
    stop = 1'b0; pause = 1'b0; strum = 1'b0;
    do_reset();

    // Stop mid-window at rom_addr=3.
    fill_rom(6'h01);
    buttons = 5'b00000;
    do_start(s); ld = s + 9;
    push_exp(1'b0, ld + 4);
    push_exp(1'b0, ld + 12);
    wait_until(ld + 17);
    check("s6_addr3", rom_addr, 3);
    check("s6_notes", notes_to_play, 1);
    stop = 1'b1;
    wait_until(ld + 18);
    stop = 1'b0;
    check("s6_stop_state", state, 0);
    check("s6_stop_addr", rom_addr, 0);
    check("s6_stop_notes", notes_to_play, 0);
    wait_until(ld + 26); check("s6_idle_held", state, 0);
    do_reset();

    // All rests: overstrum miss, no window, address wraps after 256 beats.
    fill_rom(6'h00);
    do_start(s);
    wait_until(s + 4); strum = 1'b1; push_exp(1'b0, s + 5);
    wait_until(s + 5); strum = 1'b0;
    wait_until(s + 9); check("s7_rest_notes", notes_to_play, 0); check("s7_addr1", rom_addr, 1);
    wait_until(s + 9 + 8 * 254); check("s7_addr255", rom_addr, 255);
    wait_until(s + 9 + 8 * 255);
    check("s7_addr_wrap", rom_addr, 0);
    check("s7_still_play", state, 1);
    wait_until(s + 9 + 8 * 255 + 3);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/strum_judge_ctrl.md
STRUM_JUDGE_CTRL -- requirements
Module: strum_judge_ctrl

Interface
REQ-001 SHALL have parameter BEAT_CYCLES, default 2500000, clk cycles per chart beat.
REQ-002 SHALL have parameter WINDOW_CYCLES, default 1250000, hit-window length in clk cycles; legal range is 1 <= WINDOW_CYCLES < BEAT_CYCLES.
REQ-003 SHALL have port clk  in  1  system clock; the design is single-clock, all logic on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  level; begins the song from IDLE.
REQ-006 SHALL have port pause  in  1  level; freezes play while high.
REQ-007 SHALL have port stop  in  1  level; aborts to IDLE.
REQ-008 SHALL have port buttons  in  5  fret buttons, bit0 = lane 0.
REQ-009 SHALL have port strum  in  1  strum bar, active high.
REQ-010 SHALL have port rom_addr  out  8  chart ROM address.
REQ-011 SHALL have port rom_data  in  6  chart word: [4:0] lanes, [5] end marker; valid 1 cycle after rom_addr.
REQ-012 SHALL have port notes_to_play  out  5  lanes of the open window; 0 when no window is open.
REQ-013 SHALL have ports note_hit and note_miss  out  1 each  single-cycle judgment pulses.
REQ-014 SHALL have port state  out  2  IDLE=0, PLAY=1, PAUSE=2, DONE=3.

Function
REQ-015 IDLE: start=1 SHALL move to PLAY with rom_addr=0 and the beat counter at 0.
REQ-016 PLAY: the beat counter SHALL count 0..BEAT_CYCLES-1 and wrap to 0.
REQ-017 On the terminal beat count, if rom_data[5]=1 the FSM SHALL go to DONE; otherwise rom_data[4:0] SHALL load into notes_to_play on the next edge and rom_addr SHALL increment, wrapping 255->0.
REQ-018 A loaded lane value of 0 (rest) SHALL open no window and produce no judgment.
REQ-019 A nonzero load SHALL open a window; the window counter SHALL count WINDOW_CYCLES cycles.
REQ-020 Strum rising edge (sampled strum=1, previous sample 0) with a window open SHALL give note_hit if buttons==notes_to_play, otherwise note_miss; the window SHALL then close and notes_to_play SHALL become 0.
REQ-021 Window expiry with no strum SHALL give note_miss and notes_to_play SHALL become 0.
REQ-022 Strum edge and expiry in the same cycle SHALL be judged as a strum, with exactly one pulse.
REQ-023 A strum edge with no window open while in PLAY SHALL give note_miss (overstrum).
REQ-024 note_hit and note_miss SHALL never both be 1 in the same cycle; either pulse SHALL be 1 only in PLAY.
REQ-025 Pulse latency SHALL be 1 cycle after the cycle in which the edge is sampled.
REQ-026 pause=1 in PLAY SHALL move to PAUSE, freezing the counters, rom_addr, notes_to_play and the open window; strum SHALL be ignored.
REQ-027 pause=0 in PAUSE SHALL return to PLAY, resuming from the frozen counts.
REQ-028 A strum held high across the pause SHALL NOT count as an edge on resume.
REQ-029 stop=1 SHALL move any state to IDLE on the next edge: notes_to_play=0, rom_addr=0, counters 0, no pulse.
REQ-030 Priority SHALL be stop > pause > start.
REQ-031 DONE SHALL hold notes_to_play=0; it SHALL be left only by stop or reset.

Reset
REQ-032 reset SHALL force state=IDLE, rom_addr=0, notes_to_play=0, note_hit=0, note_miss=0, all counters 0 and the strum history 0, from any state including mid-window.

Configuration
REQ-033 Macro STRUM_SYNC_EN defined: strum and buttons SHALL pass through 2-flop synchronizers before edge detect and compare, and pulse latency from the pin SHALL be 3 cycles.
REQ-034 Macro STRUM_SYNC_EN undefined: inputs SHALL be used directly, latency as REQ-025, and no synchronizer flops SHALL be present.

Verification (BEAT_CYCLES=8, WINDOW_CYCLES=4, STRUM_SYNC_EN undefined)
REQ-035 Chart {0x05, 0x20}, start, buttons=00101, strum edge 2 cycles after load -> note_hit one cycle later, notes_to_play=0, then DONE at the next beat.
REQ-036 Chart {0x03}, buttons=00001 on strum -> note_miss; with no strum -> note_miss exactly 4 cycles after load.
REQ-037 Strum edge in the cycle the window expires -> exactly one pulse (hit when buttons match).
REQ-038 pause=1 for 20 cycles mid-window -> counters, rom_addr and notes_to_play unchanged; window resumes with remaining count and the held strum is ignored.
REQ-039 stop asserted mid-window at rom_addr=3 -> next cycle IDLE, rom_addr=0, notes_to_play=0, no pulse.
REQ-040 Chart of rests (0x00) with a strum edge -> note_miss (overstrum); 256-entry chart without marker -> rom_addr wraps to 0.
